// File: rtl/sd_sector_sequencer.sv
// Multi-sector read sequencer between the request logic and the SPI sd_controller.
// Captures 512 bytes per sector into a buffer, with one pending request, abort and timeout.
module sd_sector_sequencer #(
  parameter int unsigned ADDR_STEP = 1,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned TIMEOUT   = 1_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [CNT_W-1:0]  req_count,
  input  logic              abort,
  output logic [31:0]       sdc_address,
  output logic              sdc_rd,
  input  logic              sdc_ready,
  input  logic [7:0]        sdc_dout,
  input  logic              sdc_byte_available,
  output logic              buf_we,
  output logic [CNT_W+8:0]  buf_addr,
  output logic [7:0]        buf_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  sectors_done
);

  // state      | meaning
  // IDLE       | no request active; starts a fresh or pending request
  // WAIT_RDY   | waiting for the card to be ready before issuing a sector read
  // ISSUE      | sdc_rd held high until the card drops ready
  // READ       | capturing bytes on rising edges of byte_available
  // DRAIN      | sector complete, waiting for the card to return to ready
  // ABORT_WAIT | aborted; letting an in-flight sector finish without writing
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_ISSUE, S_READ, S_DRAIN, S_ABORT_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] ONE_C = 1;
  localparam logic [8:0]       ONE_B = 1;

  state_t             r_state;
  logic [31:0]        r_base;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_sector_idx;
  logic [CNT_W-1:0]   r_sectors_done;
  logic [8:0]         r_byte_idx;
  logic               r_pend_valid;
  logic [31:0]        r_pend_addr;
  logic [CNT_W-1:0]   r_pend_count;
  logic [31:0]        r_tmo;
  logic               r_bav_prev;
  logic [31:0]        r_sdc_address;
  logic               r_sdc_rd;
  logic               r_buf_we;
  logic [CNT_W+8:0]   r_buf_addr;
  logic [7:0]         r_buf_data;
  logic               r_busy;
  logic               r_done;
  logic               r_error;

  logic               w_accept;
  logic               w_rise;
  logic               w_tmo;
  logic               w_event;
  logic [31:0]        w_sector_addr;
  logic [CNT_W-1:0]   w_sd_next;
  logic [31:0]        w_ld_addr;
  logic [CNT_W-1:0]   w_ld_count;

  // Abort blocks acceptance in the same cycle, so req_ready is gated by it directly.
  assign req_ready     = ~r_pend_valid & ~abort;
  assign w_accept      = req_valid & req_ready;
  assign w_rise        = sdc_byte_available & ~r_bav_prev;
  assign w_tmo         = (r_tmo == 32'(TIMEOUT - 1));
  assign w_sector_addr = r_base + 32'(r_sector_idx) * 32'(ADDR_STEP);
  assign w_sd_next     = r_sectors_done + ONE_C;
  assign w_ld_addr     = r_pend_valid ? r_pend_addr  : req_addr;
  assign w_ld_count    = r_pend_valid ? r_pend_count : req_count;

  // Progress events take priority over a coincident timeout.
  assign w_event = (r_state == S_WAIT_RDY && sdc_ready) ||
                   (r_state == S_ISSUE && !sdc_ready) ||
                   (r_state == S_READ && w_rise) ||
                   ((r_state == S_DRAIN || r_state == S_ABORT_WAIT) && sdc_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_base         <= '0;
      r_count        <= '0;
      r_sector_idx   <= '0;
      r_sectors_done <= '0;
      r_byte_idx     <= '0;
      r_pend_valid   <= 1'b0;
      r_pend_addr    <= '0;
      r_pend_count   <= '0;
      r_tmo          <= '0;
      r_bav_prev     <= 1'b0;
      r_sdc_address  <= '0;
      r_sdc_rd       <= 1'b0;
      r_buf_we       <= 1'b0;
      r_buf_addr     <= '0;
      r_buf_data     <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_bav_prev <= sdc_byte_available;
      r_buf_we   <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      if (abort) begin
        r_pend_valid <= 1'b0;
      end else if (w_accept && r_state != S_IDLE) begin
        r_pend_valid <= 1'b1;
        r_pend_addr  <= req_addr;
        r_pend_count <= req_count;
      end
      if (abort && r_state != S_IDLE && r_state != S_ABORT_WAIT) begin
        r_sdc_rd <= 1'b0;
        r_state  <= S_ABORT_WAIT;
        r_tmo    <= '0;
      end else if (r_state != S_IDLE && w_tmo && !w_event) begin
        r_error  <= 1'b1;
        r_sdc_rd <= 1'b0;
        r_busy   <= 1'b0;
        r_state  <= S_IDLE;
        r_tmo    <= '0;
      end else begin
        if (r_state != S_IDLE) r_tmo <= r_tmo + 32'd1;
        case (r_state)
          S_IDLE: begin
            if (!abort && (r_pend_valid || w_accept)) begin
              r_base         <= w_ld_addr;
              r_count        <= w_ld_count;
              r_sector_idx   <= '0;
              r_byte_idx     <= '0;
              r_sectors_done <= '0;
              r_pend_valid   <= 1'b0;
              r_tmo          <= '0;
              if (w_ld_count == '0) begin
                r_done <= 1'b1;
              end else begin
                r_state <= S_WAIT_RDY;
                r_busy  <= 1'b1;
              end
            end
          end
          S_WAIT_RDY: begin
            if (sdc_ready) begin
              r_sdc_address <= w_sector_addr;
              r_sdc_rd      <= 1'b1;
              r_state       <= S_ISSUE;
              r_tmo         <= '0;
            end
          end
          S_ISSUE: begin
            if (!sdc_ready) begin
              r_sdc_rd <= 1'b0;
              r_state  <= S_READ;
              r_tmo    <= '0;
            end
          end
          S_READ: begin
            if (w_rise) begin
              r_buf_we   <= 1'b1;
              r_buf_data <= sdc_dout;
              r_buf_addr <= {r_sector_idx, r_byte_idx};
              r_byte_idx <= r_byte_idx + ONE_B;
              r_tmo      <= '0;
              if (r_byte_idx == 9'd511) r_state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (sdc_ready) begin
              r_sector_idx   <= r_sector_idx + ONE_C;
              r_sectors_done <= w_sd_next;
              r_tmo          <= '0;
              if (w_sd_next == r_count) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_state <= S_WAIT_RDY;
              end
            end
          end
          S_ABORT_WAIT: begin
            if (sdc_ready) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
              r_tmo   <= '0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign sdc_address  = r_sdc_address;
  assign sdc_rd       = r_sdc_rd;
  assign buf_we       = r_buf_we;
  assign buf_addr     = r_buf_addr;
  assign buf_data     = r_buf_data;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign sectors_done = r_sectors_done;

endmodule

// File: tb/tb_sd_sector_sequencer.sv
// Bench for sd_sector_sequencer: behavioural SD card, output monitor and per-scenario tasks.
// Uses ADDR_STEP=512 (byte addressing) and TIMEOUT=1000 for the whole run.
module tb_sd_sector_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_count = '0;
  logic        abort = 1'b0;
  logic [31:0] sdc_address;
  logic        sdc_rd;
  logic        sdc_ready;
  logic [7:0]  sdc_dout;
  logic        sdc_byte_available;
  logic        buf_we;
  logic [12:0] buf_addr;
  logic [7:0]  buf_data;
  logic        busy, done, error;
  logic [3:0]  sectors_done;

  sd_sector_sequencer #(.ADDR_STEP(512), .CNT_W(4), .TIMEOUT(1000)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_count(req_count), .abort(abort),
    .sdc_address(sdc_address), .sdc_rd(sdc_rd), .sdc_ready(sdc_ready),
    .sdc_dout(sdc_dout), .sdc_byte_available(sdc_byte_available),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_data(buf_data),
    .busy(busy), .done(done), .error(error), .sectors_done(sectors_done)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // card model: byte b of a sector carries (b mod 256) ^ card_key
  logic [7:0] card_key = 8'h00;
  int card_hi = 4, card_lo = 2, card_stall_at = 1000;
  bit card_kill = 1'b0;
  bit card_active = 1'b0;

  initial begin
    sdc_ready = 1'b1; sdc_byte_available = 1'b0; sdc_dout = 8'h00;
    forever begin
      @(negedge clk);
      if (card_kill) begin
        sdc_ready = 1'b1; sdc_byte_available = 1'b0;
      end else if (sdc_rd && sdc_ready) begin
        sdc_ready = 1'b0; card_active = 1'b1;
        for (int b = 0; b < 512 && !card_kill; b++) begin
          if (b == card_stall_at) begin
            while (!card_kill) @(negedge clk);
          end else begin
            sdc_byte_available = 1'b0;
            sdc_dout = 8'(b) ^ card_key;
            repeat (card_lo) @(negedge clk);
            sdc_byte_available = 1'b1;
            repeat (card_hi) @(negedge clk);
          end
        end
        sdc_byte_available = 1'b0;
        if (!card_kill) repeat (3) @(negedge clk);
        sdc_ready = 1'b1; card_active = 1'b0;
      end
    end
  end

  // output monitor, sampled 1 ns after each rising edge
  logic [12:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic [31:0] rd_addr_q[$];
  int cyc = 0, done_n = 0, err_n = 0, lat_bad = 0, done_busy_bad = 0, err_rd_bad = 0;
  int last_wr_cyc = 0, err_cyc = 0, done_cyc = 0;
  logic rd_prev = 1'b0, bav_last = 1'b0;

  initial forever begin
    @(posedge clk); #1;
    cyc++;
    if (buf_we) begin
      wr_addr_q.push_back(buf_addr);
      wr_data_q.push_back(buf_data);
      last_wr_cyc = cyc;
      if (!(sdc_byte_available && !bav_last)) lat_bad++;
    end
    if (sdc_rd && !rd_prev) rd_addr_q.push_back(sdc_address);
    if (done) begin done_n++; done_cyc = cyc; if (busy) done_busy_bad++; end
    if (error) begin err_n++; err_cyc = cyc; if (sdc_rd) err_rd_bad++; end
    rd_prev = sdc_rd;
    bav_last = sdc_byte_available;
  end

  task automatic clear_mon();
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    done_n = 0; err_n = 0; lat_bad = 0; done_busy_bad = 0; err_rd_bad = 0;
  endtask

  // Reference: entry k of a request is buffer address k with data (k mod 256) ^ key.
  function automatic int write_errs(input int first, input int nbytes, input logic [7:0] key);
    int e = 0;
    for (int k = 0; k < nbytes; k++) begin
      if (first + k >= wr_addr_q.size()) e++;
      else if (wr_addr_q[first+k] !== 13'(k) || wr_data_q[first+k] !== (8'(k) ^ key)) e++;
    end
    return e;
  endfunction

  // what: 0 = writes >= n, 1 = done pulses >= n, 2 = error pulses >= n, 3 = busy low
  task automatic wait_for(input int what, input int n, input int budget, output bit ok);
    int k = 0;
    ok = 1'b0;
    while (k < budget && !ok) begin
      @(negedge clk);
      k++;
      case (what)
        0: ok = (wr_addr_q.size() >= n);
        1: ok = (done_n >= n);
        2: ok = (err_n >= n);
        default: ok = !busy;
      endcase
    end
  endtask

  task automatic send_req(input logic [31:0] a, input logic [3:0] c);
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_count = c;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({sdc_address, sdc_rd, buf_we, buf_addr, buf_data} !== 55'd0) begin
      errors++;
      $display("FAIL reset_datapath: addr=%h rd=%b we=%b baddr=%0d bdata=%h, required all zero",
               sdc_address, sdc_rd, buf_we, buf_addr, buf_data);
    end
    checks++;
    if ({busy, done, error, sectors_done, req_ready} !== 8'b0000_0001) begin
      errors++;
      $display("FAIL reset_status: busy=%b done=%b error=%b sectors_done=%0d req_ready=%b, required 0 0 0 0 1",
               busy, done, error, sectors_done, req_ready);
    end
  endtask

  task automatic test_single_sector();
    bit ok;
    card_key = 8'h00; card_hi = 4; card_lo = 2;
    clear_mon();
    send_req(32'h800, 4'd1);
    checks++;
    if (busy !== 1'b1 || sdc_rd !== 1'b0) begin
      errors++; $display("FAIL accept_latency: busy=%b rd=%b, required busy=1 rd=0", busy, sdc_rd);
    end
    @(negedge clk);
    checks++;
    if (sdc_rd !== 1'b1 || sdc_address !== 32'h800) begin
      errors++; $display("FAIL rd_latency: rd=%b addr=%h, required rd=1 addr=00000800", sdc_rd, sdc_address);
    end
    wait_for(1, 1, 6000, ok);
    repeat (5) @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_done_wait: no done within budget"); end
    checks++;
    if (wr_addr_q.size() != 512 || write_errs(0, 512, card_key) != 0) begin
      errors++; $display("FAIL single_writes: %0d writes with %0d bad, required 512 with 0 bad",
                         wr_addr_q.size(), write_errs(0, 512, card_key));
    end
    checks++;
    if (done_n != 1 || sectors_done !== 4'd1 || busy !== 1'b0 || done_busy_bad != 0) begin
      errors++; $display("FAIL single_status: done=%0d sectors_done=%0d busy=%b done_with_busy=%0d, required 1 1 0 0",
                         done_n, sectors_done, busy, done_busy_bad);
    end
    checks++;
    if (lat_bad != 0) begin
      errors++; $display("FAIL byte_latency: %0d writes not one cycle after a byte_available rise, required 0", lat_bad);
    end
  endtask

  task automatic test_multi_sector();
    bit ok;
    int bad = 0;
    card_key = 8'($urandom); card_hi = 2; card_lo = 1;
    clear_mon();
    send_req(32'h1000, 4'd3);
    wait_for(1, 1, 15000, ok);
    repeat (5) @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL multi_done_wait: no done within budget"); end
    for (int s = 0; s < 3; s++)
      if (s >= rd_addr_q.size() || rd_addr_q[s] !== 32'h1000 + 32'(s) * 32'd512) bad++;
    checks++;
    if (rd_addr_q.size() != 3 || bad != 0) begin
      errors++; $display("FAIL multi_addresses: %0d reads with %0d bad, required 3 reads 1000/1200/1400",
                         rd_addr_q.size(), bad);
    end
    checks++;
    if (wr_addr_q.size() != 1536 || write_errs(0, 1536, card_key) != 0) begin
      errors++; $display("FAIL multi_writes: %0d writes with %0d bad, required 1536 with 0 bad",
                         wr_addr_q.size(), write_errs(0, 1536, card_key));
    end
    checks++;
    if (done_n != 1 || sectors_done !== 4'd3) begin
      errors++; $display("FAIL multi_status: done=%0d sectors_done=%0d, required 1 and 3", done_n, sectors_done);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [31:0] a1;
    a1 = $urandom;
    card_key = 8'($urandom); card_hi = 2; card_lo = 1;
    clear_mon();
    send_req(a1, 4'd1);
    wait_for(0, 100, 3000, ok);
    send_req(32'h2000, 4'd1);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL pending_ready: req_ready=%b, required 0", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h3000; req_count = 4'd1;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    wait_for(1, 2, 10000, ok);
    repeat (30) @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_done_wait: done count %0d within budget, required 2", done_n); end
    checks++;
    if (rd_addr_q.size() != 2 || rd_addr_q[0] !== a1 || rd_addr_q[1] !== 32'h2000) begin
      errors++; $display("FAIL b2b_addresses: %0d reads, required exactly %h then 00002000",
                         rd_addr_q.size(), a1);
    end
    checks++;
    if (wr_addr_q.size() != 1024 || write_errs(0, 512, card_key) != 0 || write_errs(512, 512, card_key) != 0) begin
      errors++; $display("FAIL b2b_writes: %0d writes, required 1024 as two sector-0 runs", wr_addr_q.size());
    end
    checks++;
    if (done_n != 2 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_status: done=%0d busy=%b req_ready=%b, required 2 0 1", done_n, busy, req_ready);
    end
  endtask

  task automatic test_abort();
    bit ok;
    card_key = 8'($urandom); card_hi = 1; card_lo = 1;
    clear_mon();
    send_req($urandom, 4'd2);
    wait_for(0, 50, 2000, ok);
    send_req(32'h4000, 4'd1);
    wait_for(0, 101, 2000, ok);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b1 || sdc_rd !== 1'b0) begin
      errors++; $display("FAIL abort_wait: busy=%b rd=%b, required busy=1 rd=0", busy, sdc_rd);
    end
    wait_for(3, 0, 3000, ok);
    checks++;
    if (!ok || sdc_ready !== 1'b1) begin
      errors++; $display("FAIL abort_busy_fall: fell=%b sdc_ready=%b, required 1 1", ok, sdc_ready);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (wr_addr_q.size() != 101 || write_errs(0, 101, card_key) != 0) begin
      errors++; $display("FAIL abort_writes: %0d writes, required 101 (bytes 0..100)", wr_addr_q.size());
    end
    checks++;
    if (done_n != 0 || err_n != 0 || rd_addr_q.size() != 1 || req_ready !== 1'b1) begin
      errors++; $display("FAIL abort_status: done=%0d error=%0d reads=%0d req_ready=%b, required 0 0 1 1",
                         done_n, err_n, rd_addr_q.size(), req_ready);
    end
  endtask

  task automatic test_abort_idle();
    clear_mon();
    @(negedge clk);
    abort = 1'b1; req_valid = 1'b1; req_addr = 32'h5000; req_count = 4'd1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL abort_vs_req_ready: req_ready=%b, required 0", req_ready);
    end
    @(negedge clk);
    abort = 1'b0; req_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rd_addr_q.size() != 0 || done_n != 0) begin
      errors++; $display("FAIL abort_vs_req: busy=%b reads=%0d done=%0d, required 0 0 0",
                         busy, rd_addr_q.size(), done_n);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    card_key = 8'($urandom); card_hi = 4; card_lo = 2; card_stall_at = 300;
    clear_mon();
    send_req($urandom, 4'd1);
    wait_for(0, 100, 2000, ok);
    send_req(32'h7000, 4'd0);
    wait_for(2, 1, 4000, ok);
    repeat (5) @(negedge clk);
    checks++;
    if (!ok || err_n != 1) begin
      errors++; $display("FAIL timeout_error: error pulses=%0d, required 1", err_n);
    end
    checks++;
    if (err_cyc - last_wr_cyc != 1000) begin
      errors++; $display("FAIL timeout_latency: %0d cycles after last capture, required 1000", err_cyc - last_wr_cyc);
    end
    checks++;
    if (wr_addr_q.size() != 300 || write_errs(0, 300, card_key) != 0 || err_rd_bad != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_state: writes=%0d rd_at_error=%0d busy=%b, required 300 0 0",
                         wr_addr_q.size(), err_rd_bad, busy);
    end
    checks++;
    if (done_n != 1 || done_cyc != err_cyc + 1) begin
      errors++; $display("FAIL timeout_pending: done=%0d at +%0d cycles, required 1 at +1",
                         done_n, done_cyc - err_cyc);
    end
    card_kill = 1'b1;
    repeat (10) @(negedge clk);
    card_kill = 1'b0; card_stall_at = 1000;
  endtask

  task automatic test_reset_midread();
    bit ok;
    card_hi = 4; card_lo = 2;
    clear_mon();
    send_req($urandom, 4'd2);
    wait_for(0, 50, 2000, ok);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({sdc_address, sdc_rd, buf_we, buf_addr, buf_data, busy, done, error, sectors_done, req_ready} !== 63'd1) begin
      errors++; $display("FAIL reset_midread: addr=%h rd=%b we=%b baddr=%0d busy=%b sd=%0d rdy=%b, required reset values",
                         sdc_address, sdc_rd, buf_we, buf_addr, busy, sectors_done, req_ready);
    end
    card_kill = 1'b1;
    repeat (10) @(negedge clk);
    reset_n = 1'b1; card_kill = 1'b0;
    repeat (2) @(negedge clk);
    clear_mon();
    send_req(32'h6000, 4'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_count_done: done=%b busy=%b, required 1 0", done, busy);
    end
    @(negedge clk);
    repeat (5) @(negedge clk);
    checks++;
    if (done_n != 1 || rd_addr_q.size() != 0) begin
      errors++; $display("FAIL zero_count_once: done=%0d reads=%0d, required 1 0", done_n, rd_addr_q.size());
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [31:0] base;
    int cnt, bad;
    for (int it = 0; it < 3; it++) begin
      base = $urandom; cnt = $urandom_range(1, 2);
      card_key = 8'($urandom); card_hi = $urandom_range(1, 4); card_lo = $urandom_range(1, 2);
      clear_mon();
      send_req(base, 4'(cnt));
      wait_for(1, 1, 15000, ok);
      repeat (5) @(negedge clk);
      bad = 0;
      for (int s = 0; s < cnt; s++)
        if (s >= rd_addr_q.size() || rd_addr_q[s] !== base + 32'(s * 512)) bad++;
      checks++;
      if (!ok || rd_addr_q.size() != cnt || bad != 0) begin
        errors++; $display("FAIL random_addresses[%0d]: %0d reads with %0d bad, required %0d from %h",
                           it, rd_addr_q.size(), bad, cnt, base);
      end
      checks++;
      if (wr_addr_q.size() != cnt * 512 || write_errs(0, cnt * 512, card_key) != 0 ||
          done_n != 1 || sectors_done !== 4'(cnt)) begin
        errors++; $display("FAIL random_data[%0d]: writes=%0d done=%0d sectors_done=%0d, required %0d 1 %0d",
                           it, wr_addr_q.size(), done_n, sectors_done, cnt * 512, cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_sector();
    test_multi_sector();
    test_back_to_back();
    test_abort();
    test_abort_idle();
    test_timeout();
    test_reset_midread();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
